// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with grant lock; ARB_TIMEOUT_EN adds a MAX_HOLD forced release with a TIMEOUT pulse.
// Latency: 1 clock from REQ to GNT; exactly one idle cycle between consecutive grants.
// Backpressure: the owner holds GNT until it sends DONE or drops REQ; other requesters wait.
module rr_arbiter_lock #(
  parameter int N        = 4,
  parameter int W        = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic [N-1:0] REQ,
  input  logic         DONE,
  output logic [N-1:0] GNT,
  output logic         BUSY,
  output logic [W-1:0] OWNER,
  output logic         TIMEOUT
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q;
  logic [W-1:0] ptr_q;

  logic [N-1:0] low_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] pick_src;
  logic [N-1:0] win_onehot;
  logic [W-1:0] win_idx;
  logic [W-1:0] owner_nxt;
  logic         normal_rel;
  logic         hold_limit;

  // Requests at or above PTR get first pick; fall back to the full vector to wrap around.
  always_comb begin
    low_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr_q)) low_mask[i] = 1'b1;
    end
    masked_req = REQ & ~low_mask;
    pick_src   = (masked_req != '0) ? masked_req : REQ;
    win_onehot = pick_src & (~pick_src + N'(1));
    win_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (win_onehot[i]) win_idx = win_idx | W'(i);
    end
  end

  assign owner_nxt  = (OWNER == W'(N - 1)) ? '0 : OWNER + W'(1);
  assign normal_rel = DONE || !REQ[OWNER];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hcnt_q;
  logic       timeout_q;

  // hcnt_q counts completed grant cycles, so the limit is reached on cycle MAX_HOLD.
  assign hold_limit = (hcnt_q == 8'(MAX_HOLD - 1));
  assign TIMEOUT    = timeout_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        hcnt_q <= '0;
      end else if (normal_rel || hold_limit) begin
        hcnt_q    <= '0;
        timeout_q <= !normal_rel;
      end else begin
        hcnt_q <= hcnt_q + 8'd1;
      end
    end
  end
`else
  // MAX_HOLD only matters in the timeout build.
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign hold_limit      = 1'b0;
  assign TIMEOUT         = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      GNT     <= '0;
      BUSY    <= 1'b0;
      OWNER   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ != '0) begin
            GNT     <= win_onehot;
            OWNER   <= win_idx;
            BUSY    <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (normal_rel || hold_limit) begin
            GNT     <= '0;
            BUSY    <= 1'b0;
            ptr_q   <= owner_nxt;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
